// File: rtl/fifo_sync_param_if.sv
// Capture FIFO bus: write side, read side, flag controls and status outputs.
// clk and reset stay plain ports on the FIFO itself.
interface fifo_sync_param_if #(
  parameter int pDATA_WIDTH = 18,
  parameter int pDEPTH_LOG2 = 10
);
  logic [pDATA_WIDTH-1:0] I_data;
  logic                   I_wr;
  logic                   I_fifo_read;
  logic                   I_fifo_flush;
  logic                   I_clear_read_flags;
  logic                   I_clear_write_flags;
  logic [pDEPTH_LOG2:0]   I_full_thresh;
  logic [pDEPTH_LOG2:0]   I_empty_thresh;
  logic                   I_custom_fifo_stat_flag;
  logic [pDATA_WIDTH-1:0] O_data;
  logic [pDEPTH_LOG2:0]   O_count;
  logic                   O_fifo_full;
  logic                   O_fifo_empty;
  logic                   O_fifo_write_allowed;
  logic                   O_fifo_overflow_blocked;
  logic [5:0]             O_fifo_status;
  logic [pDEPTH_LOG2:0]   O_high_water;

  modport master (
    output I_data, I_wr, I_fifo_read, I_fifo_flush, I_clear_read_flags,
           I_clear_write_flags, I_full_thresh, I_empty_thresh, I_custom_fifo_stat_flag,
    input  O_data, O_count, O_fifo_full, O_fifo_empty, O_fifo_write_allowed,
           O_fifo_overflow_blocked, O_fifo_status, O_high_water
  );

  modport slave (
    input  I_data, I_wr, I_fifo_read, I_fifo_flush, I_clear_read_flags,
           I_clear_write_flags, I_full_thresh, I_empty_thresh, I_custom_fifo_stat_flag,
    output O_data, O_count, O_fifo_full, O_fifo_empty, O_fifo_write_allowed,
           O_fifo_overflow_blocked, O_fifo_status, O_high_water
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock capture FIFO with registered read data, exported fill level,
// programmable full/empty thresholds, one-cycle flush and sticky
// overflow/underflow flags.
// Optional feature: define FIFO_HIGH_WATER_EN to keep a high-water mark.
module fifo_sync_param #(
  parameter int pDATA_WIDTH = 18,
  parameter int pDEPTH_LOG2 = 10
) (
  input logic              cwusb_clk,
  input logic              reset_n,
  fifo_sync_param_if.slave bus
);
  localparam int CW = pDEPTH_LOG2 + 1;
  localparam int DEPTH_WORDS = 1 << pDEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH = {1'b1, {pDEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [pDEPTH_LOG2-1:0] PTR_ONE = pDEPTH_LOG2'(1);

  // Status word bit positions as decoded by the register block
  localparam int STAT_EMPTY      = 0;
  localparam int STAT_UNDERFLOW  = 1;
  localparam int STAT_EMPTY_THR  = 2;
  localparam int STAT_FULL       = 3;
  localparam int STAT_OVERFLOW   = 4;
  localparam int STAT_CUSTOM     = 5;

  logic [pDATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [pDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [pDEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [pDATA_WIDTH-1:0] data_q;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic empty, full, wr_room, rd_ok, wr_ok, ovf_set, unf_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH);
  // A flush swallows any concurrent read/write without touching the flags
  assign rd_ok   = bus.I_fifo_read & ~empty & ~bus.I_fifo_flush;
  assign wr_room = ~full | rd_ok;
  assign wr_ok   = bus.I_wr & wr_room & ~bus.I_fifo_flush;
  assign ovf_set = bus.I_wr & ~wr_room & ~bus.I_fifo_flush;
  assign unf_set = bus.I_fifo_read & empty & ~bus.I_fifo_flush;

  // Next-state for pointers, fill level and sticky flags (set beats clear)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.I_fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_ok && !rd_ok) count_d = count_q + CNT_ONE;
      else if (rd_ok && !wr_ok) count_d = count_q - CNT_ONE;
    end
    ovf_d = ovf_set | (ovf_q & ~bus.I_clear_write_flags);
    unf_d = unf_set | (unf_q & ~bus.I_clear_read_flags);
  end

  // Storage array: plain RAM write port, no reset
  always_ff @(posedge cwusb_clk) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.I_data;
  end

  // Control state and registered read data
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (rd_ok) data_q <= mem[rd_ptr_q];
    end
  end

`ifdef FIFO_HIGH_WATER_EN
  logic [CW-1:0] hw_q, hw_d;

  // A new maximum wins over a clear issued in the same cycle
  always_comb begin
    if (count_d > hw_q) hw_d = count_d;
    else if (bus.I_clear_read_flags) hw_d = '0;
    else hw_d = hw_q;
  end

  // High-water register; flush leaves it alone
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) hw_q <= '0;
    else hw_q <= hw_d;
  end

  assign bus.O_high_water = hw_q;
`else
  assign bus.O_high_water = '0;
`endif

  assign bus.O_data                  = data_q;
  assign bus.O_count                 = count_q;
  assign bus.O_fifo_full             = full;
  assign bus.O_fifo_empty            = empty;
  // Advisory only; thresholds above depth leave it high until full
  assign bus.O_fifo_write_allowed    = (count_q < bus.I_full_thresh) & ~full;
  assign bus.O_fifo_overflow_blocked = ovf_q;

  always_comb begin
    bus.O_fifo_status                 = '0;
    bus.O_fifo_status[STAT_EMPTY]     = empty;
    bus.O_fifo_status[STAT_UNDERFLOW] = unf_q;
    bus.O_fifo_status[STAT_EMPTY_THR] = (count_q <= bus.I_empty_thresh) & ~empty;
    bus.O_fifo_status[STAT_FULL]      = full;
    bus.O_fifo_status[STAT_OVERFLOW]  = ovf_q;
    bus.O_fifo_status[STAT_CUSTOM]    = bus.I_custom_fifo_stat_flag;
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at depth 16: a vector table for
// fill/overflow/drain/underflow plus hand-written multi-cycle sequences.
module tb_fifo_sync_param;
  localparam int DW = 18;
  localparam int LG = 4;

  typedef struct {
    logic          wr, rd, fl, cr, cw;
    logic [DW-1:0] data;
    logic [LG:0]   exp_count;
    logic          exp_ovf, exp_unf;
    logic [DW-1:0] exp_dout;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [LG:0] fthr, ethr;
  logic custom;
  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_d;

  fifo_sync_param_if #(.pDATA_WIDTH(DW), .pDEPTH_LOG2(LG)) bus ();

  fifo_sync_param #(.pDATA_WIDTH(DW), .pDEPTH_LOG2(LG)) dut (
    .cwusb_clk(clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  assign bus.I_full_thresh           = fthr;
  assign bus.I_empty_thresh          = ethr;
  assign bus.I_custom_fifo_stat_flag = custom;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [LG:0] c, input logic ovf,
                           input logic unf, input logic [DW-1:0] d);
    logic e_empty, e_full, e_wa, e_ethr;
    logic [5:0] st;
    e_empty = (c == 0);
    e_full  = (c == 5'd16);
    e_wa    = (c < fthr) && !e_full;
    e_ethr  = (c <= ethr) && !e_empty;
    st      = {custom, ovf, e_full, e_ethr, unf, e_empty};
    check({tag, " count"},  32'(bus.O_count), 32'(c));
    check({tag, " status"}, 32'(bus.O_fifo_status), 32'(st));
    check({tag, " wr_allowed"}, 32'(bus.O_fifo_write_allowed), 32'(e_wa));
    check({tag, " full"},   32'(bus.O_fifo_full), 32'(e_full));
    check({tag, " empty"},  32'(bus.O_fifo_empty), 32'(e_empty));
    check({tag, " ovf"},    32'(bus.O_fifo_overflow_blocked), 32'(ovf));
    check({tag, " dout"},   32'(bus.O_data), 32'(d));
  endtask

  task automatic step(input logic wr, input logic rd, input logic fl, input logic cr,
                      input logic cw, input logic [DW-1:0] d);
    @(negedge clk);
    bus.I_wr = wr; bus.I_fifo_read = rd; bus.I_fifo_flush = fl;
    bus.I_clear_read_flags = cr; bus.I_clear_write_flags = cw; bus.I_data = d;
    @(posedge clk);
    #1;
    bus.I_wr = 1'b0; bus.I_fifo_read = 1'b0; bus.I_fifo_flush = 1'b0;
    bus.I_clear_read_flags = 1'b0; bus.I_clear_write_flags = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    fthr = 5'd12; ethr = 5'd3; custom = 1'b0;
    bus.I_wr = 1'b0; bus.I_fifo_read = 1'b0; bus.I_fifo_flush = 1'b0;
    bus.I_clear_read_flags = 1'b0; bus.I_clear_write_flags = 1'b0; bus.I_data = '0;

    // Reset state, including write_allowed following a zero full threshold
    #12;
    chk_state("reset", 5'd0, 1'b0, 1'b0, '0);
    check("reset high_water", 32'(bus.O_high_water), 32'd0);
    fthr = 5'd0; #1;
    check("reset wa thr0", 32'(bus.O_fifo_write_allowed), 32'd0);
    fthr = 5'd12; #1;
    @(negedge clk) reset_n = 1'b1;

    // Table: fill to full, overflow, drain, underflow, flag clears
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1, 0, 0, 0, 0, DW'(i), 5'(i + 1), 0, 0, '0});
    vecs.push_back('{1, 0, 0, 0, 0, 18'h3FFFF, 5'd16, 1, 0, '0});
    for (int j = 0; j < 16; j++)
      vecs.push_back('{0, 1, 0, 0, 0, '0, 5'(15 - j), 1, 0, DW'(j)});
    vecs.push_back('{0, 1, 0, 0, 0, '0, 5'd0, 1, 1, 18'hF});
    vecs.push_back('{0, 0, 0, 1, 0, '0, 5'd0, 1, 0, 18'hF});
    vecs.push_back('{0, 0, 0, 0, 1, '0, 5'd0, 0, 0, 18'hF});
    foreach (vecs[k]) begin
      step(vecs[k].wr, vecs[k].rd, vecs[k].fl, vecs[k].cr, vecs[k].cw, vecs[k].data);
      chk_state($sformatf("vec%0d", k), vecs[k].exp_count, vecs[k].exp_ovf,
                vecs[k].exp_unf, vecs[k].exp_dout);
    end

    // Full FIFO streaming one read and one write per cycle across wraps
    exp_d = 18'hF;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 0, DW'(18'h100 + i));
      model_q.push_back(DW'(18'h100 + i));
      chk_state($sformatf("sfill%0d", i), 5'(i + 1), 0, 0, exp_d);
    end
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 0, 0, DW'(18'h200 + i));
      exp_d = model_q.pop_front();
      model_q.push_back(DW'(18'h200 + i));
      chk_state($sformatf("stream%0d", i), 5'd16, 0, 0, exp_d);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 0, '0);
      exp_d = model_q.pop_front();
      chk_state($sformatf("sdrain%0d", i), 5'(15 - i), 0, 0, exp_d);
    end

    // Flush with a simultaneous write: word is dropped, no flag set
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, DW'(18'h50 + i));
    chk_state("preflush", 5'd5, 0, 0, exp_d);
    step(1, 0, 1, 0, 0, 18'h3AA);
    chk_state("flush", 5'd0, 0, 0, exp_d);
    step(1, 0, 0, 0, 0, 18'h77);
    step(0, 1, 0, 0, 0, '0);
    chk_state("postflush read", 5'd0, 0, 0, 18'h77);

    // First write plus read on empty: no bypass, read underflows
    step(1, 1, 0, 0, 0, 18'h123);
    chk_state("nobypass", 5'd1, 0, 1, 18'h77);
    step(0, 1, 0, 0, 0, '0);
    chk_state("nobypass read", 5'd0, 0, 1, 18'h123);
    step(0, 0, 0, 1, 0, '0);
    chk_state("unf clear", 5'd0, 0, 0, 18'h123);

    // Sticky overflow: set beats a concurrent clear, clear alone drops it
    custom = 1'b1;
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, DW'(i));
    step(1, 0, 0, 0, 0, 18'h1);
    chk_state("ovf set", 5'd16, 1, 0, 18'h123);
    step(1, 0, 0, 0, 1, 18'h2);
    chk_state("ovf set+clr", 5'd16, 1, 0, 18'h123);
    step(0, 0, 0, 0, 1, '0);
    chk_state("ovf clr", 5'd16, 0, 0, 18'h123);
    custom = 1'b0;
    step(0, 0, 1, 0, 0, '0);
    chk_state("flush full", 5'd0, 0, 0, 18'h123);

`ifdef FIFO_HIGH_WATER_EN
    step(0, 0, 0, 1, 0, '0);
    check("hw cleared", 32'(bus.O_high_water), 32'd0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, DW'(i));
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, '0);
    check("hw count2", 32'(bus.O_count), 32'd2);
    check("hw peak9", 32'(bus.O_high_water), 32'd9);
    step(0, 0, 0, 1, 0, '0);
    check("hw clr", 32'(bus.O_high_water), 32'd0);
    step(1, 0, 0, 0, 0, 18'h9);
    check("hw after write", 32'(bus.O_high_water), 32'd3);
    exp_d = 18'h6;
`else
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, DW'(i));
    check("hw tied0", 32'(bus.O_high_water), 32'd0);
    exp_d = 18'h123;
`endif

    // Asynchronous reset mid-cycle clears state without a clock edge
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_state("async reset", 5'd0, 0, 0, '0);
    @(negedge clk) reset_n = 1'b1;
    fthr = 5'd0;
    step(1, 0, 0, 0, 0, 18'h2A);
    chk_state("first write thr0", 5'd1, 0, 0, '0);
    step(0, 1, 0, 0, 0, '0);
    chk_state("first read", 5'd0, 0, 0, 18'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
